// File: rtl/id_ex_fwd.sv
// ID/EX operand bypass and hazard stage.
// Resolves RAW hazards against the in-flight EX/MEM/WB destinations, stalls decode on
// load-use, and registers resolved operands into the ID/EX boundary.
// Writes and reads on the same edge return old data, so WB must be bypassed here.
module id_ex_fwd #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [SEL_W-1:0]  id_rs1,
    input  logic [SEL_W-1:0]  id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [SEL_W-1:0]  id_rd,
    input  logic              id_rd_wr,
    input  logic              id_is_load,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ext_stall,
    input  logic              flush,
    output logic              id_ready,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [SEL_W-1:0]  ex_rd,
    output logic              ex_rd_wr,
    output logic              ex_is_load,
    output logic [SEL_W-1:0]  wb_rd,
    output logic              wb_write
);

    // Slot state. Load-ness only matters while in EX; MEM already presents load data.
    logic              ex_valid_q, ex_valid_d;
    logic [SEL_W-1:0]  ex_rd_q, ex_rd_d;
    logic              ex_rd_wr_q, ex_rd_wr_d;
    logic              ex_is_load_q, ex_is_load_d;
    logic [DATA_W-1:0] ex_op1_q, ex_op1_d;
    logic [DATA_W-1:0] ex_op2_q, ex_op2_d;
    logic              mem_valid_q, mem_valid_d;
    logic [SEL_W-1:0]  mem_rd_q, mem_rd_d;
    logic              mem_rd_wr_q, mem_rd_wr_d;
    logic              wb_valid_q, wb_valid_d;
    logic [SEL_W-1:0]  wb_rd_q, wb_rd_d;
    logic              wb_rd_wr_q, wb_rd_wr_d;

    logic              ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
    logic              load_use;
    logic [DATA_W-1:0] fwd_op1, fwd_op2;

    // Source/slot match detection, load-use hazard and decode handshake.
    always_comb begin
        ex_m1    = id_rs1_used & ex_valid_q & ex_rd_wr_q & (ex_rd_q == id_rs1);
        ex_m2    = id_rs2_used & ex_valid_q & ex_rd_wr_q & (ex_rd_q == id_rs2);
        mem_m1   = id_rs1_used & mem_valid_q & mem_rd_wr_q & (mem_rd_q == id_rs1);
        mem_m2   = id_rs2_used & mem_valid_q & mem_rd_wr_q & (mem_rd_q == id_rs2);
        wb_m1    = id_rs1_used & wb_valid_q & wb_rd_wr_q & (wb_rd_q == id_rs1);
        wb_m2    = id_rs2_used & wb_valid_q & wb_rd_wr_q & (wb_rd_q == id_rs2);
        load_use = id_valid & (ex_m1 | ex_m2) & ex_is_load_q;
        id_ready = id_valid & ~load_use & ~ext_stall & ~flush;
    end

    // Operand select, youngest producer wins; a load in EX has no result yet.
    always_comb begin
        fwd_op1 = rf_rd1;
        if (ex_m1 && !ex_is_load_q) begin
            fwd_op1 = ex_alu_result;
        end else if (mem_m1) begin
            fwd_op1 = mem_result;
        end else if (wb_m1) begin
            fwd_op1 = wb_data;
        end
        fwd_op2 = rf_rd2;
        if (ex_m2 && !ex_is_load_q) begin
            fwd_op2 = ex_alu_result;
        end else if (mem_m2) begin
            fwd_op2 = mem_result;
        end else if (wb_m2) begin
            fwd_op2 = wb_data;
        end
    end

    // Slot advance: shift when not stalled, bubble EX when decode is not accepted or on flush.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_rd_d      = ex_rd_q;
        ex_rd_wr_d   = ex_rd_wr_q;
        ex_is_load_d = ex_is_load_q;
        ex_op1_d     = ex_op1_q;
        ex_op2_d     = ex_op2_q;
        mem_valid_d  = mem_valid_q;
        mem_rd_d     = mem_rd_q;
        mem_rd_wr_d  = mem_rd_wr_q;
        wb_valid_d   = wb_valid_q;
        wb_rd_d      = wb_rd_q;
        wb_rd_wr_d   = wb_rd_wr_q;
        if (!ext_stall) begin
            wb_valid_d  = mem_valid_q;
            wb_rd_d     = mem_rd_q;
            wb_rd_wr_d  = mem_rd_wr_q;
            mem_valid_d = ex_valid_q;
            mem_rd_d    = ex_rd_q;
            mem_rd_wr_d = ex_rd_wr_q;
            if (id_ready) begin
                ex_valid_d   = 1'b1;
                ex_rd_d      = id_rd;
                ex_rd_wr_d   = id_rd_wr;
                ex_is_load_d = id_is_load;
                ex_op1_d     = fwd_op1;
                ex_op2_d     = fwd_op2;
            end else begin
                ex_valid_d   = 1'b0;
                ex_rd_wr_d   = 1'b0;
                ex_is_load_d = 1'b0;
            end
        end
        // Flush kills EX even while the rest of the pipe is frozen.
        if (flush) begin
            ex_valid_d   = 1'b0;
            ex_rd_wr_d   = 1'b0;
            ex_is_load_d = 1'b0;
        end
    end

    // Slot registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_rd_q      <= '0;
            ex_rd_wr_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_op1_q     <= '0;
            ex_op2_q     <= '0;
            mem_valid_q  <= 1'b0;
            mem_rd_q     <= '0;
            mem_rd_wr_q  <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_rd_wr_q   <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_rd_q      <= ex_rd_d;
            ex_rd_wr_q   <= ex_rd_wr_d;
            ex_is_load_q <= ex_is_load_d;
            ex_op1_q     <= ex_op1_d;
            ex_op2_q     <= ex_op2_d;
            mem_valid_q  <= mem_valid_d;
            mem_rd_q     <= mem_rd_d;
            mem_rd_wr_q  <= mem_rd_wr_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_rd_wr_q   <= wb_rd_wr_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_op1     = ex_op1_q;
    assign ex_op2     = ex_op2_q;
    assign ex_rd      = ex_rd_q;
    assign ex_rd_wr   = ex_rd_wr_q;
    assign ex_is_load = ex_is_load_q;
    assign wb_rd      = wb_rd_q;
    assign wb_write   = wb_valid_q & wb_rd_wr_q;

endmodule

// File: tb/tb_id_ex_fwd.sv
// Self-checking bench for id_ex_fwd: directed hazard scenarios with a scoreboard of
// expected EX-slot contents pushed at issue and popped one cycle later.
module tb_id_ex_fwd;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [SW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_rs1_used, id_rs2_used, id_rd_wr, id_is_load;
    logic [DW-1:0] rf_rd1, rf_rd2, ex_alu_result, mem_result, wb_data;
    logic          ext_stall, flush;
    logic          id_ready, ex_valid, ex_rd_wr, ex_is_load, wb_write;
    logic [DW-1:0] ex_op1, ex_op2;
    logic [SW-1:0] ex_rd, wb_rd;

    typedef struct {
        logic [SW-1:0] rd;
        logic          wr;
        logic          ld;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic          c1;
        logic          c2;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    id_ex_fwd #(.DATA_W(DW), .SEL_W(SW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .id_rd         (id_rd),
        .id_rd_wr      (id_rd_wr),
        .id_is_load    (id_is_load),
        .rf_rd1        (rf_rd1),
        .rf_rd2        (rf_rd2),
        .ex_alu_result (ex_alu_result),
        .mem_result    (mem_result),
        .wb_data       (wb_data),
        .ext_stall     (ext_stall),
        .flush         (flush),
        .id_ready      (id_ready),
        .ex_valid      (ex_valid),
        .ex_op1        (ex_op1),
        .ex_op2        (ex_op2),
        .ex_rd         (ex_rd),
        .ex_rd_wr      (ex_rd_wr),
        .ex_is_load    (ex_is_load),
        .wb_rd         (wb_rd),
        .wb_write      (wb_write)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_data(input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                            input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                            input logic [DW-1:0] wbd);
        rf_rd1        = r1;
        rf_rd2        = r2;
        ex_alu_result = alu;
        mem_result    = mem;
        wb_data       = wbd;
    endtask

    // Present one decode instruction for one cycle and check the EX slot it produces.
    task automatic issue(input logic [SW-1:0] rs1, input logic u1, input logic [SW-1:0] rs2,
                         input logic u2, input logic [SW-1:0] rd, input logic wr,
                         input logic ld, input logic exp_rdy, input logic [DW-1:0] e1,
                         input logic c1, input logic [DW-1:0] e2, input logic c2,
                         input string tag);
        exp_t e;
        @(negedge clk);
        id_valid    = 1'b1;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_rd_wr    = wr;
        id_is_load  = ld;
        #1;
        check_eq({tag, ".id_ready"}, 32'(id_ready), 32'(exp_rdy));
        if (exp_rdy) begin
            e = '{rd: rd, wr: wr, ld: ld, op1: e1, op2: e2, c1: c1, c2: c2};
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        id_valid = 1'b0;
        if (exp_rdy) begin
            e = sb_q.pop_front();
            check_eq({tag, ".ex_valid"}, 32'(ex_valid), 32'd1);
            check_eq({tag, ".ex_rd"}, 32'(ex_rd), 32'(e.rd));
            check_eq({tag, ".ex_rd_wr"}, 32'(ex_rd_wr), 32'(e.wr));
            check_eq({tag, ".ex_is_load"}, 32'(ex_is_load), 32'(e.ld));
            if (e.c1) check_eq({tag, ".ex_op1"}, ex_op1, e.op1);
            if (e.c2) check_eq({tag, ".ex_op2"}, ex_op2, e.op2);
        end else if (!ext_stall) begin
            check_eq({tag, ".bubble"}, 32'(ex_valid), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            id_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // Three writers of r5 in flight, then a reader of r5.
    task automatic prio(input logic w2, input logic w3, input logic [DW-1:0] exp,
                        input string tag);
        idle(3);
        set_data(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        issue(0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0, 0, {tag, ".w1"});
        issue(0, 0, 0, 0, 5, w2, 0, 1, 0, 0, 0, 0, {tag, ".w2"});
        issue(0, 0, 0, 0, 5, w3, 0, 1, 0, 0, 0, 0, {tag, ".w3"});
        set_data(32'hF, 32'h3, 32'hA, 32'hB, 32'hC);
        issue(5, 1, 0, 0, 12, 1, 0, 1, exp, 1, 32'h3, 1, tag);
    endtask

    task automatic check_hold(input string tag);
        check_eq({tag, ".ex_valid"}, 32'(ex_valid), 32'd1);
        check_eq({tag, ".ex_rd"}, 32'(ex_rd), 32'd10);
        check_eq({tag, ".ex_rd_wr"}, 32'(ex_rd_wr), 32'd1);
        check_eq({tag, ".ex_op1"}, ex_op1, 32'h1C);
        check_eq({tag, ".ex_op2"}, ex_op2, 32'h2C);
        check_eq({tag, ".wb_write"}, 32'(wb_write), 32'd1);
        check_eq({tag, ".wb_rd"}, 32'(wb_rd), 32'd8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b1;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_used = 1'b1; id_rs2_used = 1'b1; id_rd_wr = 1'b1; id_is_load = 1'b0;
        ext_stall = 1'b0;
        flush = 1'b0;
        set_data(32'h1, 32'h2, 32'h3, 32'h4, 32'h5);

        // Reset held two cycles with a valid decode instruction.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        id_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst.ex_valid", 32'(ex_valid), 32'd0);
        check_eq("rst.ex_op1", ex_op1, 32'd0);
        check_eq("rst.ex_op2", ex_op2, 32'd0);
        check_eq("rst.ex_rd_wr", 32'(ex_rd_wr), 32'd0);
        check_eq("rst.wb_write", 32'(wb_write), 32'd0);
        check_eq("rst.wb_rd", 32'(wb_rd), 32'd0);
        check_eq("rst.id_ready", 32'(id_ready), 32'd0);

        // EX forward.
        idle(3);
        set_data(32'h11, 32'h22, 32'h0, 32'h0, 32'h0);
        issue(1, 1, 2, 1, 3, 1, 0, 1, 32'h11, 1, 32'h22, 1, "exf0");
        set_data(32'h99, 32'h7, 32'h55, 32'h66, 32'h77);
        issue(3, 1, 1, 1, 4, 1, 0, 1, 32'h55, 1, 32'h7, 1, "exf1");

        // Forwarding priority EX > MEM > WB.
        prio(1, 1, 32'hA, "prio_ex");
        prio(1, 0, 32'hB, "prio_mem");
        prio(0, 0, 32'hC, "prio_wb");

        // Load-use: one bubble then MEM forward.
        idle(3);
        set_data(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        issue(0, 0, 0, 0, 2, 1, 1, 1, 0, 0, 0, 0, "ld");
        set_data(32'h5, 32'h6, 32'hBAD, 32'h1234, 32'h0);
        issue(2, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, "lu_stall");
        issue(2, 1, 0, 0, 6, 1, 0, 1, 32'h1234, 1, 32'h6, 1, "lu_go");

        // Unused source after a load: no stall.
        idle(3);
        set_data(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        issue(0, 0, 0, 0, 2, 1, 1, 1, 0, 0, 0, 0, "ld2");
        set_data(32'h77, 32'h6, 32'hBAD, 32'h1234, 32'h0);
        issue(2, 0, 2, 0, 6, 1, 0, 1, 32'h77, 1, 32'h6, 1, "lu_unused");

        // WB bypass over a stale rf read.
        idle(3);
        set_data(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        issue(0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0, 0, "wb_prod");
        idle(2);
        check_eq("wb.wb_write", 32'(wb_write), 32'd1);
        check_eq("wb.wb_rd", 32'(wb_rd), 32'd7);
        set_data(32'hBEEF, 32'h1, 32'h2, 32'h3, 32'hDEAD);
        issue(7, 1, 0, 0, 13, 1, 0, 1, 32'hDEAD, 1, 32'h1, 1, "wb_byp");

        // ext_stall holds every slot.
        idle(3);
        set_data(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        issue(0, 0, 0, 0, 8, 1, 0, 1, 0, 0, 0, 0, "st_a");
        issue(0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0, "st_b");
        set_data(32'h1C, 32'h2C, 32'h0, 32'h0, 32'h0);
        issue(0, 0, 0, 0, 10, 1, 0, 1, 32'h1C, 1, 32'h2C, 1, "st_c");
        ext_stall = 1'b1;
        set_data(32'h91, 32'h92, 32'h93, 32'h94, 32'h95);
        for (int i = 0; i < 3; i++) begin
            issue(10, 1, 3, 1, 14, 1, 0, 0, 0, 0, 0, 0, "stall");
            check_hold("hold");
        end

        // Flush under stall kills only EX; MEM/WB frozen.
        flush = 1'b1;
        issue(10, 1, 3, 1, 14, 1, 0, 0, 0, 0, 0, 0, "flush_st");
        check_eq("flush_st.ex_valid", 32'(ex_valid), 32'd0);
        check_eq("flush_st.ex_rd_wr", 32'(ex_rd_wr), 32'd0);
        check_eq("flush_st.wb_write", 32'(wb_write), 32'd1);
        check_eq("flush_st.wb_rd", 32'(wb_rd), 32'd8);
        ext_stall = 1'b0;
        flush = 1'b0;
        idle(1);
        check_eq("post_flush.wb_rd", 32'(wb_rd), 32'd9);
        check_eq("post_flush.wb_write", 32'(wb_write), 32'd1);
        idle(1);
        check_eq("post_flush.wb_bubble", 32'(wb_write), 32'd0);

        // Flush alone refuses decode and bubbles EX.
        flush = 1'b1;
        issue(0, 0, 0, 0, 15, 1, 0, 0, 0, 0, 0, 0, "flush");
        flush = 1'b0;

        // Synchronous reset while stalled clears everything.
        idle(3);
        set_data(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        issue(0, 0, 0, 0, 11, 1, 0, 1, 0, 0, 0, 0, "rs_d");
        issue(0, 0, 0, 0, 12, 1, 0, 1, 0, 0, 0, 0, "rs_e");
        set_data(32'h3D, 32'h4D, 32'h0, 32'h0, 32'h0);
        issue(0, 0, 0, 0, 13, 1, 0, 1, 32'h3D, 1, 32'h4D, 1, "rs_f");
        check_eq("rs_pre.wb_write", 32'(wb_write), 32'd1);
        @(negedge clk);
        ext_stall = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rs.ex_valid", 32'(ex_valid), 32'd0);
        check_eq("rs.ex_rd", 32'(ex_rd), 32'd0);
        check_eq("rs.ex_op1", ex_op1, 32'd0);
        check_eq("rs.ex_op2", ex_op2, 32'd0);
        check_eq("rs.wb_write", 32'(wb_write), 32'd0);
        check_eq("rs.wb_rd", 32'(wb_rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ext_stall = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rs_post.wb_write", 32'(wb_write), 32'd0);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_ex_fwd.md
Name: id_ex_fwd

Overview:
- Operand bypass and hazard stage between the register file read port and the execute stage.
- Each cycle it takes the decoded instruction's source selects and the rf read data, then resolves RAW hazards in three steps:
  - forwards from EX, MEM or WB;
  - stalls decode on load-use;
  - registers the resolved operands into the ID/EX boundary.
- Tracks in-flight destinations (EX, MEM, WB slots) and drives the rf write select/enable from its WB slot.
- rf writes and reads on the same negedge with old-data-on-collision, so WB bypass is mandatory here.

Parameters:
- DATA_W, REGFILE_WIDTH (wi23_defs, 32): operand/result width.
- SEL_W, 5: register select width.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  decode presents an instruction
- id_rs1, id_rs2  in  SEL_W  source selects (same values driven to rf read1regsel/read2regsel)
- id_rs1_used, id_rs2_used  in  1  source actually consumed
- id_rd  in  SEL_W  destination select
- id_rd_wr  in  1  instruction writes id_rd
- id_is_load  in  1  result produced in MEM, not EX
- rf_rd1, rf_rd2  in  DATA_W  rf read data for id_rs1/id_rs2, valid this cycle
- ex_alu_result  in  DATA_W  combinational EX result of instruction in EX slot
- mem_result  in  DATA_W  result of instruction in MEM slot (ALU or load data)
- wb_data  in  DATA_W  result of instruction in WB slot
- ext_stall  in  1  downstream busy; freeze all slots
- flush  in  1  branch/jump redirect; kill decode instruction and EX slot
- id_ready  out  1  decode instruction accepted this cycle
- ex_valid  out  1  EX slot holds real instruction
- ex_op1, ex_op2  out  DATA_W  resolved operands (registered)
- ex_rd  out  SEL_W  EX destination
- ex_rd_wr  out  1  EX destination write enable
- ex_is_load  out  1  EX instruction is a load
- wb_rd  out  SEL_W  to rf writeregsel
- wb_write  out  1  to rf write

Behaviour:
- Slots: EX, MEM, WB. Each slot holds {valid, rd, rd_wr, is_load}. EX also holds op1/op2.
- Reset (rst_n=0 at posedge): all slot fields 0, ex_op1=ex_op2=0. All outputs 0 except id_ready, which is combinational.
- Match definition, per source s in {rs1, rs2}, against slot X: id_rsN_used & X.valid & X.rd_wr & (X.rd == id_rsN). Register 0 is not special.
- Forward select, priority order:
  - EX match & !EX.is_load: ex_alu_result
  - else MEM match: mem_result
  - else WB match: wb_data
  - else: rf_rdN
- load_use = id_valid & (EX match on either used source) & EX.is_load.
- id_ready = id_valid & !load_use & !ext_stall & !flush.
- Posedge, no reset, ext_stall=0:
  - WB <= MEM; MEM <= EX.
  - If id_ready: EX <= {1, id_rd, id_rd_wr, id_is_load}, ex_op1/op2 <= forwarded values.
  - Otherwise EX <= bubble (valid=0, rd_wr=0, is_load=0). op1/op2 hold their previous values.
- Load-use: exactly one bubble. Next cycle the load is in MEM and mem_result is forwarded, so id_ready rises with no second stall.
- ext_stall=1: all slots and outputs hold. id_ready=0.
- flush=1:
  - EX <= bubble regardless of ext_stall; flush has priority over ext_stall for the EX slot only.
  - MEM/WB advance normally, or hold if ext_stall.
  - Decode instruction not accepted.
- wb_write = WB.valid & WB.rd_wr; wb_rd = WB.rd.
  - Under ext_stall the same write repeats. This is idempotent and permitted.
- Unused sources never match, so never forward or stall.
- Bubbles never match (rd_wr=0).
- Latency: decode-to-ex_* outputs is 1 cycle when accepted.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with id_valid=1 -> after release, ex_valid=0, ex_op1=ex_op2=0, wb_write=0.
- EX forward:
  - Cycle 0: issue ADD r3 (rd_wr=1).
  - Cycle 1: issue r4=r3+r1 with ex_alu_result=0x00000055, rf_rd2=0x7.
  - Expected: ex_op1=0x55, ex_op2=0x7, id_ready=1 both cycles.
- Priority:
  - r5 is written by three consecutive instructions, then consumed.
  - Drive ex_alu_result=0xA, mem_result=0xB, wb_data=0xC.
  - Expected: ex_op1=0xA.
  - Repeat with the EX write disabled -> 0xB; with MEM also disabled -> 0xC.
- Load-use:
  - Issue LD r2, then consumer of r2 with mem_result=0x1234 on the following cycle.
  - Expected: id_ready=0 for 1 cycle, EX bubble (ex_valid=0), then ex_op1=0x1234.
  - Same consumer with rs_used=0 -> no stall.
- WB bypass:
  - Instruction in WB writes r7=0xDEAD while decode reads r7 with rf_rd1=0xBEEF (stale).
  - Expected: ex_op1=0xDEAD; wb_write=1, wb_rd=7.
- ext_stall/flush:
  - ext_stall for 3 cycles -> all ex_*, wb_* outputs constant, id_ready=0.
  - flush with ext_stall=1 -> ex_valid=0 next cycle, MEM/WB unchanged.
  - Synchronous reset asserted mid-stall -> all slots cleared on that posedge.
